vga_scan_timer: RTL
===================

Name: vga_scan_timer

Overview:
Raster timing generator for the TinyQV VGA peripheral. Produces 1024x768 XGA timing from the 64 MHz project clock (about 59.1 Hz frame rate). Drives the beam position, sync and blank signals, the per-line retrace strobe and the sticky CPU interrupt that the VGA peripheral uses to advance its VRAM index and to colour pixels. Sits directly upstream of the peripheral's pixel and VRAM-indexing logic.

Parameters:
H_VISIBLE, 1024, active clocks per line
H_NARROW, 960, active clocks per line when narrow_960=1
H_FRONT, 24, horizontal front porch clocks
H_SYNC, 136, hsync pulse clocks
H_BACK, 160, horizontal back porch clocks (line total 1344)
V_VISIBLE, 768, active lines
V_FRONT, 3, vertical front porch lines
V_SYNC, 6, vsync pulse lines
V_BACK, 29, vertical back porch lines (frame total 806)

Ports:
clk  in  1  project clock, 64 MHz
rst_n  in  1  synchronous active-low reset
cli  in  1  clear interrupt; level, sampled each clock
enable_interrupt_on_hblank  in  1  arm interrupt at start of each visible line's hblank
enable_interrupt_on_vblank  in  1  arm interrupt at start of vblank
narrow_960  in  1  1: blank from x=960 instead of x=1024
x  out  11  horizontal counter, 0..1343
y  out  10  vertical counter, 0..805
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
retrace  out  1  one-clock strobe per line
blank  out  1  1 outside the active area
frame_start  out  1  one-clock strobe at x=0, y=0
interrupt  out  1  sticky interrupt request

Behaviour:
- Reset is decided: reset rst_n, synchronous, active-low; clock clk.
- Reset values: x=0, y=0, hsync=1, vsync=1, blank=0, retrace=0, frame_start=0, interrupt=0.
- Reset mid-operation returns all outputs to these values on the next edge, with no residual strobes.
- x increments every clock. At 1343 it wraps to 0 and y increments. y wraps 805->0 when x wraps.
- All outputs are registers. Sync, blank and strobe flops are loaded from the next-state counter values, so each output always describes the x/y it is presented with. There is no latency between x/y and their decodes.
- Horizontal decode: hsync=0 for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), which is 1048..1183.
- Vertical decode: vsync=0 for y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), which is 771..776, for all x of those lines.
- Blank: blank=1 when x >= W or y >= V_VISIBLE. W is H_NARROW if narrow_960=1, otherwise H_VISIBLE.
- A narrow_960 change affects blank from the next computed cycle; a mid-line toggle is allowed.
- Retrace: retrace=1 for exactly one clock, when x=H_VISIBLE+H_FRONT (hsync falling edge), on every line including vblank lines.
- frame_start: 1 for exactly one clock, when x=0 and y=0. It is not asserted on the reset cycle itself.
- Interrupt events:
  - hblank event: x=H_VISIBLE and y<V_VISIBLE and enable_interrupt_on_hblank=1.
  - vblank event: x=0 and y=V_VISIBLE and enable_interrupt_on_vblank=1.
  - Events are evaluated on the presented counter values. interrupt goes to 1 on the following edge.
- Interrupt set/clear: interrupt stays 1 until a cycle with cli=1 and no event. If cli=1 coincides with an event, set wins and interrupt stays 1, so no event is lost.
- Changing an enable does not itself clear a pending interrupt.
- Counters never stall. cli and the enables have no effect on timing.

Test Plan:
1. Reset held 3 clocks, then released -> x=0, y=0, hsync=1, vsync=1, blank=0, interrupt=0; x=1343 after 1343 clocks, then x=0, y=1.
2. Run one line -> hsync low exactly 136 clocks starting at x=1048; retrace high only at x=1048; blank=1 from x=1024 to x=1343.
3. Run one full frame (806*1344 clocks) -> vsync low on y=771..776 only; blank=1 for all y>=768; frame_start pulses once, at the wrap to x=0, y=0.
4. narrow_960=1 -> blank rises at x=960. Toggle narrow_960 to 0 at x=970 -> blank returns to 0 one clock later, until x=1024.
5. hblank enable only -> interrupt rises the clock after x=1024 on y=5; cli pulse clears it; no event on y=770. A cli pulse coincident with the x=1024 event leaves interrupt=1.
6. vblank enable only -> exactly one interrupt set per frame, the clock after y=768, x=0. Assert rst_n=0 at x=500, y=300 -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/vga_scan_timer.sv
// XGA raster timing generator: beam counters plus registered sync, blank,
// strobe and sticky interrupt outputs, all aligned with the x/y they accompany.
module vga_scan_timer #(
  parameter int H_VISIBLE = 1024,
  parameter int H_NARROW  = 960,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BACK    = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
  input  logic        enable_interrupt_on_hblank,
  input  logic        enable_interrupt_on_vblank,
  input  logic        narrow_960,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        frame_start,
  output logic        interrupt
);

  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] H_NAR_W  = 11'(H_NARROW);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        retrace_q, retrace_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic        irq_q, irq_d;
  logic [10:0] width;
  logic        irq_event;

  // Decodes use the next counter values so every output lines up with x/y.
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    width         = narrow_960 ? H_NAR_W : H_VIS_W;
    hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
    blank_d       = (x_d >= width) || (y_d >= V_VIS);
    retrace_d     = (x_d == HS_START);
    frame_start_d = (x_d == '0) && (y_d == '0);
    irq_event     = ((x_q == H_VIS_W) && (y_q < V_VIS) && enable_interrupt_on_hblank) ||
                    ((x_q == '0) && (y_q == V_VIS) && enable_interrupt_on_vblank);
    // Set has priority over clear so a coincident event is never dropped.
    irq_d         = irq_event || (irq_q && !cli);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      retrace_q     <= 1'b0;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      retrace_q     <= retrace_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      irq_q         <= irq_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign retrace     = retrace_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign interrupt   = irq_q;

endmodule
